// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM driver for a discrete RGB LED; duties reload only at period boundaries.
// Define RGB_PWM_GAMMA_EN to insert the (c*(c+1))>>8 gamma map on the duty load path.
module rgb_pwm_driver #(
  parameter int PRESCALE = 1
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] rgb,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        period_start
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre_reg, pre_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        period_start_reg;
  logic        tick;
  logic        load;
  logic [2:0]  pwm_vec;

  function automatic logic [7:0] map_level(input logic [7:0] c);
`ifdef RGB_PWM_GAMMA_EN
    logic [15:0] sq;
    sq = {8'd0, c} * ({8'd0, c} + 16'd1);
    return sq[15:8];
`else
    return c;
`endif
  endfunction

  assign tick = (pre_reg == PRE_MAX);
  // Loading only when both counters sit at zero keeps every pulse whole.
  assign load = enable && (cnt_reg == 8'd0) && (pre_reg == 16'd0);

  always_comb begin
    pre_next = tick ? 16'd0 : 16'(pre_reg + 16'd1);
    cnt_next = tick ? 8'(cnt_reg + 8'd1) : cnt_reg;
  end

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      pre_reg          <= 16'd0;
      cnt_reg          <= 8'd0;
      period_start_reg <= 1'b0;
    end else if (!enable) begin
      pre_reg          <= 16'd0;
      cnt_reg          <= 8'd0;
      period_start_reg <= 1'b0;
    end else begin
      pre_reg          <= pre_next;
      cnt_reg          <= cnt_next;
      period_start_reg <= load;
    end
  end

  // Channel gi drives byte gi of rgb: 0 = blue, 1 = green, 2 = red.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0] level;
      logic [7:0] duty_reg;
      logic [7:0] duty_eff;
      logic       pwm_reg;

      assign level    = map_level(rgb[gi*8 +: 8]);
      assign duty_eff = load ? level : duty_reg;

      always_ff @(posedge clka) begin
        if (!rst_n) begin
          duty_reg <= 8'd0;
          pwm_reg  <= 1'b0;
        end else begin
          if (load) duty_reg <= level;
          pwm_reg <= enable && (cnt_reg < duty_eff);
        end
      end

      assign pwm_vec[gi] = pwm_reg;
    end
  endgenerate

  assign pwm_b        = pwm_vec[0];
  assign pwm_g        = pwm_vec[1];
  assign pwm_r        = pwm_vec[2];
  assign period_start = period_start_reg;

endmodule
